lidar_frame_tx: RTL
===================

LIDAR_FRAME_TX -- requirements
Module: lidar_frame_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, sets clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame request.
- ct  in  8  frame type byte.
- lsn  in  8  sample count, 0..255.
- fsa  in  16  first-sample angle.
- lsa  in  16  last-sample angle.
- sample_addr  out  8  sample buffer read address.
- sample_data  in  16  buffer word; valid in the same cycle as sample_addr (combinational read).
- txd  out  1  UART serial output; idle high.
- busy  out  1  high from the accepted start until frame completion.
- frame_done  out  1  one-cycle pulse after the last stop bit.

Function
REQ-003 The frame SHALL be this byte sequence: 0x55, 0xAA, ct, lsn, fsa[7:0], fsa[15:8], lsa[7:0], lsa[15:8], cs[7:0], cs[15:8], then for i=0..lsn-1: sample[i][7:0], sample[i][15:8].
REQ-004 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit exactly CLKS_PER_BIT cycles, with no idle gap between bytes of a frame.
REQ-005 A start seen while busy=0 SHALL be accepted; ct, lsn, fsa and lsa are latched in that cycle, and busy rises on the next cycle.
REQ-006 A start seen while busy=1 SHALL be ignored, with no effect on the current frame.
REQ-007 States SHALL be IDLE -> CALC -> SEND -> DONE -> IDLE.
- IDLE waits for start.
- CALC steps sample_addr from 0 to lsn-1, one word per cycle.
- SEND serialises the frame.
- DONE lasts one cycle, asserts frame_done, and clears busy.
REQ-008 cs SHALL be the 16-bit XOR of: 0xAA55, {lsn,ct}, fsa, lsa, and every sample word.
REQ-009 In SEND, sample_addr SHALL hold the index of the sample being transmitted; the low and high bytes of a word come from a single read latched at that word's low-byte start bit.
REQ-010 When lsn=0, CALC SHALL last exactly one cycle and the frame SHALL be 10 bytes.
REQ-011 The txd falling edge of the first start bit SHALL occur lsn+2 cycles after the accepted start (1 cycle for lsn=0 is replaced by the 1-cycle CALC of REQ-010: total 2).
REQ-012 Total busy duration SHALL be CALC cycles + (10+2*lsn)*10*CLKS_PER_BIT cycles + 1.
REQ-013 sample_addr SHALL wrap naturally at 8 bits; lsn=255 reads addresses 0..254 only.
REQ-014 txd SHALL be registered, so that no glitches appear on it.
REQ-015 A start arriving in the same cycle as frame_done SHALL be ignored; a new frame is accepted from the following cycle.

Reset
REQ-016 While reset=0, outputs SHALL be: txd=1, busy=0, frame_done=0, sample_addr=0; state IDLE; the checksum accumulator and all counters cleared.
REQ-017 Reset asserted mid-frame SHALL drive txd high immediately (asynchronously) and abandon the frame without asserting frame_done.
REQ-018 After reset release, the block SHALL accept start on the first rising edge.

Configuration
REQ-019 Macro LIDAR_TX_CHECKSUM_EN, when defined, SHALL enable the CALC state and the cs computation per REQ-007 and REQ-008.
REQ-020 Without LIDAR_TX_CHECKSUM_EN, CALC SHALL be skipped (IDLE -> SEND), cs bytes are sent as 0x00 0x00, the first start bit falls 1 cycle after start, and busy duration excludes CALC cycles.

Verification
REQ-021 Default config, macro defined, ct=0x00, lsn=1, fsa=0, lsa=0, sample[0]=0x0000 -> txd bytes 55 AA 00 01 00 00 00 00 55 AB 00 00, then frame_done is a single pulse.
REQ-022 lsn=0, ct=0x21, fsa=0x1234, lsa=0x5678 -> 10 bytes 55 AA 21 00 34 12 78 56, then cs=0xAA55^0x0021^0x1234^0x5678 sent low byte first; busy lasts 1+100*CLKS_PER_BIT+1 cycles.
REQ-023 lsn=255 with sample[i]={i,i} -> 520 bytes; sample_addr never exceeds 254; cs matches a bench model.
REQ-024 Second start pulse issued mid-frame -> the frame is unchanged and exactly one frame_done is seen.
REQ-025 Reset pulled low during byte 5 -> txd=1 in the same cycle, busy=0, no frame_done; a new start then yields a complete correct frame.
REQ-026 Macro undefined, REQ-021 stimulus -> cs bytes are 00 00 and the first start bit falls 1 cycle after start.

Source files
------------

// File: rtl/lidar_frame_tx.sv
`timescale 1ns/1ps
// lidar_frame_tx: sends one LiDAR scan frame (header, checksum, sample words) as 8N1 UART bytes.
// Define LIDAR_TX_CHECKSUM_EN to enable the CALC pass that reads the buffer and builds the checksum.
module lidar_frame_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ct,
    input  logic [7:0]  lsn,
    input  logic [15:0] fsa,
    input  logic [15:0] lsa,
    output logic [7:0]  sample_addr,
    input  logic [15:0] sample_data,
    output logic        txd,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SEND,
        S_DONE
    } state_t;

    localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t             r_state;
    state_t             w_next;

    logic [7:0]         r_ct;
    logic [7:0]         r_lsn;
    logic [15:0]        r_fsa;
    logic [15:0]        r_lsa;
    logic [15:0]        r_word;
    logic [7:0]         r_addr;
    logic [CNT_W-1:0]   r_baud;
    logic [3:0]         r_bit;
    logic [9:0]         r_byte;
    logic [9:0]         r_last_byte;
    logic               r_txd;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_baud_end;
    logic               w_frame_end;
    logic [15:0]        w_cs;
    logic [7:0]         w_byte;
    logic               w_bit;

`ifdef LIDAR_TX_CHECKSUM_EN
    logic [15:0]        r_cs;
    logic [8:0]         r_calc_cnt;
    logic               w_calc_end;

    // CALC runs one cycle past the last read so the frame starts from a settled checksum.
    assign w_calc_end = (r_calc_cnt == {1'b0, r_lsn});
    assign w_cs       = r_cs;
`else
    assign w_cs       = 16'h0000;
`endif

    // The cycle frame_done is high still belongs to the finished frame.
    assign w_accept    = start && (r_state == S_IDLE) && !r_done;
    assign w_baud_end  = (r_baud == BAUD_LAST);
    assign w_frame_end = w_baud_end && (r_bit == 4'd9) && (r_byte == r_last_byte);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
`ifdef LIDAR_TX_CHECKSUM_EN
            S_IDLE:  if (w_accept) w_next = S_CALC;
            S_CALC:  if (w_calc_end) w_next = S_SEND;
`else
            S_IDLE:  if (w_accept) w_next = S_SEND;
            S_CALC:  w_next = S_IDLE;
`endif
            S_SEND:  if (w_frame_end) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_byte)
            10'd0:   w_byte = 8'h55;
            10'd1:   w_byte = 8'hAA;
            10'd2:   w_byte = r_ct;
            10'd3:   w_byte = r_lsn;
            10'd4:   w_byte = r_fsa[7:0];
            10'd5:   w_byte = r_fsa[15:8];
            10'd6:   w_byte = r_lsa[7:0];
            10'd7:   w_byte = r_lsa[15:8];
            10'd8:   w_byte = w_cs[7:0];
            10'd9:   w_byte = w_cs[15:8];
            default: w_byte = r_byte[0] ? r_word[15:8] : r_word[7:0];
        endcase
    end

    always_comb begin
        w_bit = 1'b1;
        if (r_bit == 4'd0) begin
            w_bit = 1'b0;
        end else if (r_bit <= 4'd8) begin
            w_bit = w_byte[3'(r_bit - 4'd1)];
        end
    end

    // NOTE: txd resets to the idle level asynchronously so an abandoned frame never leaves the line low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ct        <= '0;
            r_lsn       <= '0;
            r_fsa       <= '0;
            r_lsa       <= '0;
            r_word      <= '0;
            r_addr      <= '0;
            r_baud      <= '0;
            r_bit       <= '0;
            r_byte      <= '0;
            r_last_byte <= '0;
            r_txd       <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef LIDAR_TX_CHECKSUM_EN
            r_cs        <= '0;
            r_calc_cnt  <= '0;
`endif
        end else begin
            r_done <= (r_state == S_DONE);

            if (w_accept) begin
                r_ct        <= ct;
                r_lsn       <= lsn;
                r_fsa       <= fsa;
                r_lsa       <= lsa;
                r_last_byte <= 10'd9 + {1'b0, lsn, 1'b0};
                r_busy      <= 1'b1;
                r_addr      <= '0;
                r_baud      <= '0;
                r_bit       <= '0;
                r_byte      <= '0;
`ifdef LIDAR_TX_CHECKSUM_EN
                r_cs        <= 16'hAA55 ^ {lsn, ct} ^ fsa ^ lsa;
                r_calc_cnt  <= '0;
`endif
            end

            case (r_state)
`ifdef LIDAR_TX_CHECKSUM_EN
                S_CALC: begin
                    r_calc_cnt <= r_calc_cnt + 9'd1;
                    if (w_calc_end) begin
                        r_addr <= '0;
                    end else begin
                        r_cs <= r_cs ^ sample_data;
                        if (r_addr != r_lsn - 8'd1) begin
                            r_addr <= r_addr + 8'd1;
                        end
                    end
                end
`endif
                S_SEND: begin
                    r_txd <= w_bit;
                    // One buffer read per sample, taken on its low byte's start bit.
                    if (r_baud == '0 && r_bit == 4'd0 && r_byte >= 10'd10 && !r_byte[0]) begin
                        r_word <= sample_data;
                    end
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 4'd9) begin
                            r_bit <= '0;
                            if (!w_frame_end) begin
                                r_byte <= r_byte + 10'd1;
                                if (r_byte[0] && r_byte >= 10'd11) begin
                                    r_addr <= r_addr + 8'd1;
                                end
                            end
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign txd         = r_txd;
    assign busy        = r_busy;
    assign frame_done  = r_done;
    assign sample_addr = r_addr;

endmodule
